// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan scheduler and its helpers.
package seg7_pkg;

  localparam logic [4:0] SEG7_MAX_CODE = 5'd19;

  typedef struct packed {
    logic [4:0] code;
    logic       parity;
    logic       valid;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_code_screen.sv
// Combinational screen of a digit code: even-parity check and legal-range check.
module seg7_code_screen
  import seg7_pkg::*;
(
  input  logic [4:0] code_i,
  input  logic       parity_i,
  output logic       par_ok_o,
  output logic       in_range_o
);

  assign par_ok_o   = ~(^{code_i, parity_i});
  assign in_range_o = (code_i <= SEG7_MAX_CODE);

endmodule

// File: rtl/seg7_scan_sched.sv
// Round-robin scan scheduler: stores screened digit codes and walks them in
// blank/show slots, presenting one code/parity pair at a time to the decoder.
module seg7_scan_sched
  import seg7_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS   = 4,
  parameter  int unsigned SLOT_CYCLES  = 1000,
  parameter  int unsigned BLANK_CYCLES = 2,
  localparam int unsigned IDX_W        = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_digit,
  input  logic [4:0]            wr_code,
  input  logic                  wr_parity,
  input  logic                  err_clear,
  output logic [4:0]            dig_code,
  output logic                  dig_parity,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  err_flag,
  output logic [7:0]            err_count
);

  localparam int unsigned SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int unsigned TMR_W       = $clog2(SLOT_CYCLES + 1);

  scan_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  slot_t              slot_q [NUM_DIGITS];
  slot_t              slot_d [NUM_DIGITS];
  logic               err_flag_q, err_flag_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               par_ok;
  logic               in_range;
  logic               dig_in_range;
  logic               wr_fire;
  logic               err_hit;
  logic               show_c;

  seg7_code_screen u_screen (
    .code_i     (wr_code),
    .parity_i   (wr_parity),
    .par_ok_o   (par_ok),
    .in_range_o (in_range)
  );

  // Block writes to the digit currently lit so it never tears mid-slot.
  assign wr_ready     = ~(enable && (state_q == SHOW) && (wr_digit == idx_q));
  assign wr_fire      = wr_valid & wr_ready;
  assign dig_in_range = (32'(wr_digit) < NUM_DIGITS);

  assign dig_code   = slot_q[idx_q].code;
  assign dig_parity = slot_q[idx_q].parity;
  assign show_c     = enable && (state_q == SHOW) && slot_q[idx_q].valid;
  assign dig_sel    = show_c ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;

  // Scan FSM next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          timer_d = '0;
        end
        BLANK: begin
          if (timer_q == TMR_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        SHOW: begin
          if (timer_q == TMR_W'(SHOW_CYCLES - 1)) begin
            state_d = BLANK;
            timer_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write screening: out-of-range codes blank the slot, bad parity is kept for the error glyph.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_d[i] = slot_q[i];
    err_hit = 1'b0;
    if (wr_fire) begin
      if (!dig_in_range) begin
        err_hit = 1'b1;
      end else begin
        err_hit = ~par_ok | ~in_range;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (wr_digit == IDX_W'(i)) begin
            slot_d[i] = in_range ? '{code: wr_code, parity: wr_parity, valid: 1'b1} : '0;
          end
        end
      end
    end
  end

  // Error tracking; a new error takes priority over a clear.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (err_hit) begin
      err_flag_d  = 1'b1;
      err_count_d = err_clear ? 8'd1 :
                    (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
    end else if (err_clear) begin
      err_flag_d  = 1'b0;
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Directed bench for seg7_scan_sched with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [4:0] wr_code;
  logic       wr_parity;
  logic       err_clear;
  logic [4:0] dig_code;
  logic       dig_parity;
  logic [3:0] dig_sel;
  logic       err_flag;
  logic [7:0] err_count;

  int errs   = 0;
  int checks = 0;
  int t      = 0;
  bit scan   = 1'b0;

  logic [4:0] m_code [4];
  logic       m_par  [4];
  logic       m_vld  [4];

  seg7_scan_sched #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digit  (wr_digit),
    .wr_code   (wr_code),
    .wr_parity (wr_parity),
    .err_clear (err_clear),
    .dig_code  (dig_code),
    .dig_parity(dig_parity),
    .dig_sel   (dig_sel),
    .err_flag  (err_flag),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Expected display outputs from the slot model and the slot timeline.
  task automatic check_scan();
    int ix;
    logic [3:0] es;
    ix = scan ? (t / 8) % 4 : 0;
    es = 4'b0000;
    if (scan && (t % 8) >= 2 && m_vld[ix]) es[ix] = 1'b1;
    check("dig_sel", 32'(dig_sel), 32'(es));
    check("dig_code", 32'(dig_code), 32'(m_code[ix]));
    check("dig_parity", 32'(dig_parity), 32'(m_par[ix]));
  endtask

  function automatic logic m_ready(input logic [1:0] d);
    return !(scan && enable && (t % 8) >= 2 && int'(d) == (t / 8) % 4);
  endfunction

  task automatic tick();
    logic       acc;
    logic [1:0] d;
    logic [4:0] c;
    logic       p;
    #1;
    acc = wr_valid && m_ready(wr_digit) && rst_n;
    d = wr_digit;
    c = wr_code;
    p = wr_parity;
    @(posedge clk);
    t++;
    if (acc) begin
      if (c > 5'd19) begin
        m_code[d] = 5'd0; m_par[d] = 1'b0; m_vld[d] = 1'b0;
      end else begin
        m_code[d] = c; m_par[d] = p; m_vld[d] = 1'b1;
      end
    end
    @(negedge clk);
    check_scan();
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic wr(input logic [1:0] d, input logic [4:0] c, input logic p);
    wr_valid = 1'b1; wr_digit = d; wr_code = c; wr_parity = p;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 5'd0; m_par[i] = 1'b0; m_vld[i] = 1'b0;
    end
    rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_digit = 2'd0;
    wr_code = 5'd0; wr_parity = 1'b0; err_clear = 1'b0;
    @(negedge clk);

    // Reset with enable held high.
    repeat (3) tick();
    check("rst_dig_sel", 32'(dig_sel), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_err_flag", 32'(err_flag), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_dig_code", 32'(dig_code), 32'h0);
    enable = 1'b0;
    rst_n  = 1'b1;
    tick();

    // Load digits 1, 2, 3, 19 with even parity.
    wr(2'd0, 5'd1, 1'b1);
    check("wr_latency", 32'(dig_code), 32'd1);
    wr(2'd1, 5'd2, 1'b1);
    wr(2'd2, 5'd3, 1'b0);
    wr(2'd3, 5'd19, 1'b1);
    check("good_wr_no_err", 32'(err_count), 32'h0);

    // Scan order and slot timing.
    enable = 1'b1; scan = 1'b1; t = -1;
    run_to(1);  check("first_blank", 32'(dig_sel), 32'h0);
    run_to(2);  check("slot0_on", 32'(dig_sel), 32'b0001);
    run_to(7);  check("slot0_last", 32'(dig_sel), 32'b0001);
    run_to(8);  check("slot1_blank", 32'(dig_sel), 32'h0);
    run_to(10); check("slot1_on", 32'(dig_sel), 32'b0010);
    run_to(18); check("slot2_on", 32'(dig_sel), 32'b0100);
    run_to(26); check("slot3_on", 32'(dig_sel), 32'b1000);
    check("slot3_code", 32'(dig_code), 32'd19);
    run_to(34); check("wrap_on", 32'(dig_sel), 32'b0001);

    // Stall a write to the displayed digit 2.
    run_to(50);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_code = 5'd7; wr_parity = 1'b1;
    #1;
    check("stall_ready", 32'(wr_ready), 32'h0);
    while (t < 56) begin
      tick();
      if (t < 56) check("stall_hold", 32'(wr_ready), 32'h0);
    end
    check("stall_code_kept", 32'(m_code[2]), 32'd3);
    check("stall_release", 32'(wr_ready), 32'h1);
    tick();
    wr_valid = 1'b0;
    run_to(84);
    check("stall_new_code", 32'(dig_code), 32'd7);
    check("stall_new_sel", 32'(dig_sel), 32'b0100);

    // Bad parity keeps the code lit; out-of-range code blanks the slot.
    wr(2'd1, 5'd5, 1'b1);
    check("badpar_count", 32'(err_count), 32'd1);
    check("badpar_flag", 32'(err_flag), 32'h1);
    run_to(106);
    check("glyph_sel", 32'(dig_sel), 32'b0010);
    check("glyph_code", 32'(dig_code), 32'd5);
    check("glyph_par", 32'(dig_parity), 32'h1);
    run_to(112);
    wr(2'd1, 5'd25, 1'b1);
    check("range_count", 32'(err_count), 32'd2);
    run_to(138);
    check("range_blank_sel", 32'(dig_sel), 32'h0);
    check("range_blank_code", 32'(dig_code), 32'h0);

    // Drop enable mid-SHOW of digit 3, then restart.
    run_to(156);
    check("pre_drop_sel", 32'(dig_sel), 32'b1000);
    enable = 1'b0;
    #1;
    check("drop_same_cycle", 32'(dig_sel), 32'h0);
    scan = 1'b0;
    tick();
    check("idle_code", 32'(dig_code), 32'd1);
    enable = 1'b1; scan = 1'b1; t = -1;
    tick(); check("restart_blank0", 32'(dig_sel), 32'h0);
    tick(); check("restart_blank1", 32'(dig_sel), 32'h0);
    tick(); check("restart_on", 32'(dig_sel), 32'b0001);
    enable = 1'b0; scan = 1'b0;
    tick();

    // Clear, saturation, and clear colliding with an error.
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clear_count", 32'(err_count), 32'h0);
    check("clear_flag", 32'(err_flag), 32'h0);
    wr_valid = 1'b1; wr_digit = 2'd3; wr_code = 5'd25; wr_parity = 1'b0;
    repeat (254) tick();
    check("count_254", 32'(err_count), 32'd254);
    repeat (46) tick();
    check("count_sat", 32'(err_count), 32'd255);
    check("sat_flag", 32'(err_flag), 32'h1);
    err_clear = 1'b1;
    tick();
    check("clear_vs_err_count", 32'(err_count), 32'd1);
    check("clear_vs_err_flag", 32'(err_flag), 32'h1);
    err_clear = 1'b0; wr_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
